// File: rtl/gray_tracker.sv
// rtl/gray_tracker.sv - gray counter consumer: decode, lap extension and step/overflow health checks
module gray_tracker #(
  parameter int WIDTH     = 3,
  parameter int LAP_WIDTH = 8,
  parameter int ERR_WIDTH = 4
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Valid,
  input  logic [WIDTH-1:0]           GrayIn,
  input  logic                       OverflowIn,
  input  logic                       Clear,
  output logic [WIDTH-1:0]           Bin,
  output logic [LAP_WIDTH-1:0]       Laps,
  output logic [LAP_WIDTH+WIDTH-1:0] Total,
  output logic                       StepErr,
  output logic                       WrapErr,
  output logic [ERR_WIDTH-1:0]       ErrCount,
  output logic [1:0]                 State
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRACK   = 2'd1,
    FAULT   = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0]     BIN_MAX = '1;
  localparam logic [ERR_WIDTH-1:0] ERR_MAX = '1;

  state_t               state_q,    state_d;
  logic [WIDTH-1:0]     bin_q,      bin_d;
  logic [LAP_WIDTH-1:0] laps_q,     laps_d;
  logic                 step_err_q, step_err_d;
  logic                 wrap_err_q, wrap_err_d;
  logic [ERR_WIDTH-1:0] err_cnt_q,  err_cnt_d;
  logic [WIDTH-1:0]     prev_bin_q, prev_bin_d;
  logic                 prev_ovf_q, prev_ovf_d;

  logic [WIDTH-1:0]     dec_bin;
  logic                 is_hold;
  logic                 is_wrap;
  logic                 is_inc;
  logic                 ovf_rise;

  // Gray-to-binary decode: each binary bit is the XOR of all gray bits at or above it
  always_comb begin
    dec_bin = '0;
    dec_bin[WIDTH-1] = GrayIn[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      dec_bin[i] = dec_bin[i+1] ^ GrayIn[i];
    end
  end

  // Classify the new sample against the previous accepted one
  always_comb begin
    is_hold  = (dec_bin == prev_bin_q);
    is_wrap  = (prev_bin_q == BIN_MAX) && (dec_bin == '0);
    is_inc   = !is_wrap && (dec_bin == prev_bin_q + WIDTH'(1));
    ovf_rise = OverflowIn && !prev_ovf_q;
  end

  // Next-state and next-output computation; Clear behaves like Reset
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    laps_d     = laps_q;
    step_err_d = 1'b0;
    wrap_err_d = 1'b0;
    err_cnt_d  = err_cnt_q;
    prev_bin_d = prev_bin_q;
    prev_ovf_d = prev_ovf_q;

    if (Clear) begin
      state_d    = IDLE;
      bin_d      = '0;
      laps_d     = '0;
      err_cnt_d  = '0;
      prev_bin_d = '0;
      prev_ovf_d = 1'b0;
    end else begin
      if (Valid) begin
        prev_bin_d = dec_bin;
        prev_ovf_d = OverflowIn;
      end
      case (state_q)
        IDLE: begin
          if (Valid) begin
            bin_d   = dec_bin;
            state_d = TRACK;
          end
        end
        TRACK: begin
          if (Valid) begin
            bin_d = dec_bin;
            // A repeated value means the upstream counter is paused: nothing to check
            if (!is_hold) begin
              if (is_wrap) begin
                laps_d     = laps_q + LAP_WIDTH'(1);
                wrap_err_d = !OverflowIn;
              end else begin
                wrap_err_d = ovf_rise;
                if (!is_inc) begin
                  step_err_d = 1'b1;
                  err_cnt_d  = (err_cnt_q == ERR_MAX) ? err_cnt_q : err_cnt_q + ERR_WIDTH'(1);
                  state_d    = FAULT;
                end
              end
            end
          end
        end
        FAULT: begin
          // Keep following the input for debug visibility; counters stay frozen
          if (Valid) begin
            bin_d = dec_bin;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and registered outputs, synchronous active-high reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      laps_q     <= '0;
      step_err_q <= 1'b0;
      wrap_err_q <= 1'b0;
      err_cnt_q  <= '0;
      prev_bin_q <= '0;
      prev_ovf_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      laps_q     <= laps_d;
      step_err_q <= step_err_d;
      wrap_err_q <= wrap_err_d;
      err_cnt_q  <= err_cnt_d;
      prev_bin_q <= prev_bin_d;
      prev_ovf_q <= prev_ovf_d;
    end
  end

  assign Bin      = bin_q;
  assign Laps     = laps_q;
  assign Total    = {laps_q, bin_q};
  assign StepErr  = step_err_q;
  assign WrapErr  = wrap_err_q;
  assign ErrCount = err_cnt_q;
  assign State    = state_q;

endmodule

// File: tb/tb_gray_tracker.sv
// tb/tb_gray_tracker.sv - self-checking bench for gray_tracker against a behavioural model
module tb_gray_tracker;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Valid = 1'b0;
  logic [2:0]  GrayIn = 3'd0;
  logic        OverflowIn = 1'b0;
  logic        Clear = 1'b0;
  logic [2:0]  Bin;
  logic [7:0]  Laps;
  logic [10:0] Total;
  logic        StepErr;
  logic        WrapErr;
  logic [3:0]  ErrCount;
  logic [1:0]  State;

  int checks = 0;
  int failures = 0;

  // Model: mode 0=idle 1=track 2=fault; counts kept as plain integers
  int m_mode, m_bin, m_laps, m_step, m_wrap, m_err, m_prev, m_povf;

  gray_tracker dut (
    .Clk(Clk), .Reset(Reset), .Valid(Valid), .GrayIn(GrayIn), .OverflowIn(OverflowIn),
    .Clear(Clear), .Bin(Bin), .Laps(Laps), .Total(Total), .StepErr(StepErr),
    .WrapErr(WrapErr), .ErrCount(ErrCount), .State(State)
  );

  always #5 Clk = ~Clk;

  wire logic [29:0] dut_vec = {Bin, Laps, Total, StepErr, WrapErr, ErrCount, State};

  function automatic int g_of(int b);
    return b ^ (b >> 1);
  endfunction

  // Inverse gray by search over the code table
  function automatic int b_of(int g);
    for (int b = 0; b < 8; b++) if (g_of(b) == g) return b;
    return 0;
  endfunction

  function automatic logic [29:0] exp_vec();
    return {3'(m_bin), 8'(m_laps), 8'(m_laps), 3'(m_bin), 1'(m_step), 1'(m_wrap),
            4'(m_err), 2'(m_mode)};
  endfunction

  task automatic model_step(bit v, int g, bit o, bit c, bit r);
    int nb;
    m_step = 0;
    m_wrap = 0;
    if (r || c) begin
      m_mode = 0; m_bin = 0; m_laps = 0; m_err = 0; m_prev = 0; m_povf = 0;
      return;
    end
    if (!v) return;
    nb = b_of(g);
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1 && nb != m_prev) begin
      if (m_prev == 7 && nb == 0) begin
        m_laps = (m_laps + 1) % 256;
        m_wrap = !o;
      end else begin
        m_wrap = (o && !m_povf);
        if (nb != m_prev + 1) begin
          m_step = 1;
          if (m_err < 15) m_err = m_err + 1;
          m_mode = 2;
        end
      end
    end
    m_bin  = nb;
    m_prev = nb;
    m_povf = o;
  endtask

  task automatic drive(bit v, int g, bit o, bit c, bit r);
    Valid = v; GrayIn = 3'(g); OverflowIn = o; Clear = c; Reset = r;
    @(posedge Clk);
    model_step(v, g, o, c, r);
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 1);
    drive(1, 5, 1, 0, 1);
    checks++;
    if (dut_vec !== 30'd0) begin
      failures++; $display("FAIL reset: got %h exp %h", dut_vec, 30'd0);
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_count_sequence();
    drive(0, 0, 0, 0, 1);
    for (int b = 0; b < 8; b++) begin
      drive(1, g_of(b), 0, 0, 0);
      checks++;
      if (dut_vec !== exp_vec() || Bin !== 3'(b)) begin
        failures++; $display("FAIL seq b=%0d: got %h exp %h", b, dut_vec, exp_vec());
      end
    end
    drive(1, 0, 1, 0, 0);
    checks++;
    if (Total !== 11'd8 || Laps !== 8'd1 || StepErr !== 1'b0 || WrapErr !== 1'b0 || State !== 2'd1) begin
      failures++; $display("FAIL seq_wrap: got total=%0d laps=%0d se=%b we=%b st=%0d exp 8 1 0 0 1",
                           Total, Laps, StepErr, WrapErr, State);
    end
  endtask

  task automatic test_hold();
    drive(1, g_of(1), 0, 0, 0);
    drive(1, g_of(2), 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 3'b011, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, $urandom_range(0, 7), 1, 0, 0);
      checks++;
      if (Bin !== 3'd2 || StepErr !== 1'b0 || WrapErr !== 1'b0 || ErrCount !== 4'd0 ||
          dut_vec !== exp_vec()) begin
        failures++; $display("FAIL hold %0d: got %h exp %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_step_error();
    drive(0, 0, 0, 0, 1);
    drive(1, 3'b000, 0, 0, 0);
    drive(1, 3'b001, 0, 0, 0);
    drive(1, 3'b010, 0, 0, 0);
    checks++;
    if (Bin !== 3'd3 || StepErr !== 1'b1 || ErrCount !== 4'd1 || State !== 2'd2) begin
      failures++; $display("FAIL step_err: got bin=%0d se=%b ec=%0d st=%0d exp 3 1 1 2",
                           Bin, StepErr, ErrCount, State);
    end
    drive(1, 3'b110, 0, 0, 0);
    checks++;
    if (StepErr !== 1'b0 || Laps !== 8'd0 || Bin !== 3'd4 || dut_vec !== exp_vec()) begin
      failures++; $display("FAIL fault_follow: got %h exp %h", dut_vec, exp_vec());
    end
    for (int b = 5; b < 8; b++) drive(1, g_of(b), 0, 0, 0);
    drive(1, 0, 1, 0, 0);
    checks++;
    if (Laps !== 8'd0 || WrapErr !== 1'b0 || State !== 2'd2) begin
      failures++; $display("FAIL fault_frozen: got laps=%0d we=%b st=%0d exp 0 0 2", Laps, WrapErr, State);
    end
    drive(1, g_of(1), 0, 1, 0);
    checks++;
    if (dut_vec !== 30'd0) begin
      failures++; $display("FAIL clear: got %h exp %h", dut_vec, 30'd0);
    end
  endtask

  task automatic test_wrap_err();
    drive(0, 0, 0, 0, 1);
    for (int b = 0; b < 8; b++) drive(1, g_of(b), 0, 0, 0);
    drive(1, 3'b000, 0, 0, 0);
    checks++;
    if (Laps !== 8'd1 || WrapErr !== 1'b1 || StepErr !== 1'b0) begin
      failures++; $display("FAIL wrap_no_ovf: got laps=%0d we=%b se=%b exp 1 1 0", Laps, WrapErr, StepErr);
    end
    drive(1, 3'b001, 0, 0, 0);
    checks++;
    if (WrapErr !== 1'b0) begin
      failures++; $display("FAIL wrap_pulse_len: got %b exp 0", WrapErr);
    end
    drive(0, 0, 0, 0, 1);
    for (int b = 0; b < 4; b++) drive(1, g_of(b), 0, 0, 0);
    drive(1, 3'b110, 1, 0, 0);
    checks++;
    if (WrapErr !== 1'b1 || Laps !== 8'd0 || Bin !== 3'd4 || State !== 2'd1) begin
      failures++; $display("FAIL ovf_rise: got we=%b laps=%0d bin=%0d st=%0d exp 1 0 4 1",
                           WrapErr, Laps, Bin, State);
    end
  endtask

  task automatic test_lap_wrap();
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0);
    for (int lap = 1; lap <= 256; lap++) begin
      for (int b = 1; b < 8; b++) drive(1, g_of(b), 0, 0, 0);
      drive(1, 0, 1, 0, 0);
      if (lap <= 3 || lap >= 255) begin
        checks++;
        if (dut_vec !== exp_vec() || Laps !== 8'(lap % 256) || WrapErr !== 1'b0) begin
          failures++; $display("FAIL lap %0d: got %h exp %h", lap, dut_vec, exp_vec());
        end
      end
    end
    checks++;
    if (Total !== 11'd0) begin
      failures++; $display("FAIL lap_rollover_total: got %0d exp 0", Total);
    end
  endtask

  task automatic test_reset_mid_run();
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0);
    for (int i = 1; i <= 21; i++) drive(1, g_of(i % 8), (i % 8) == 0, 0, 0);
    checks++;
    if (Bin !== 3'd5 || Laps !== 8'd2) begin
      failures++; $display("FAIL pre_reset: got bin=%0d laps=%0d exp 5 2", Bin, Laps);
    end
    drive(1, g_of(6), 0, 0, 1);
    checks++;
    if (dut_vec !== 30'd0) begin
      failures++; $display("FAIL mid_reset: got %h exp %h", dut_vec, 30'd0);
    end
    drive(1, g_of(3), 0, 0, 0);
    checks++;
    if (Bin !== 3'd3 || StepErr !== 1'b0 || State !== 2'd1) begin
      failures++; $display("FAIL first_after_reset: got bin=%0d se=%b st=%0d exp 3 0 1", Bin, StepErr, State);
    end
  endtask

  task automatic test_random();
    int cnt = 0;
    bit ovf = 0;
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      int r = $urandom_range(0, 99);
      if (r < 3 || (m_mode == 2 && r < 12)) begin
        drive($urandom_range(0, 1), $urandom_range(0, 7), ovf, 1, 0);
      end else if (r < 25) begin
        drive(0, $urandom_range(0, 7), $urandom_range(0, 1), 0, 0);
      end else begin
        int a = $urandom_range(0, 99);
        if (a < 75) begin
          cnt = (cnt + 1) % 8;
          ovf = (cnt == 0) ? ($urandom_range(0, 5) != 0) : (($urandom_range(0, 9) == 0) ? !ovf : ovf);
        end else if (a < 92) begin
          ovf = ($urandom_range(0, 9) == 0) ? !ovf : ovf;
        end else begin
          cnt = $urandom_range(0, 7);
        end
        drive(1, g_of(cnt), ovf, 0, 0);
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL random %0d: got %h exp %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    m_mode = 0; m_bin = 0; m_laps = 0; m_step = 0; m_wrap = 0; m_err = 0; m_prev = 0; m_povf = 0;
    test_reset();
    test_count_sequence();
    test_hold();
    test_step_error();
    test_wrap_err();
    test_lap_wrap();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
